// File: rtl/bcd_clock_core.sv
`default_nettype none
// ============================================================================
// Module      : bcd_clock_core
// Description : Time-of-day core built from cascaded BCD counters for seconds
//               and minutes plus a binary 0..23 hour counter. Presents the
//               time in a run-time selectable 12/24-hour display mode and
//               emits a one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
// Ports       : i_Clk          system clock
//               i_Reset        synchronous active-high reset
//               i_Sec_Tick     1 Hz one-cycle pulse, advances one second
//               i_Minutes_Inc  manual minute advance (no carry into hours)
//               i_Hours_Inc    manual hour advance (no midnight pulse)
//               i_Mode_Toggle  flips the 12/24-hour display mode
//               o_Time         BCD {H tens, H ones, M tens, M ones}
//               o_Seconds      BCD {S tens, S ones}
//               o_PM           12-hour mode and hour 12..23
//               o_Mode_24H     current display mode (1 = 24-hour)
//               o_Midnight     registered rollover pulse
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_clock_core #(
  parameter int unsigned START_HOURS   = 0,
  parameter int unsigned START_MINUTES = 0,
  parameter int unsigned START_SECONDS = 0,
  parameter int unsigned RESET_24H     = 0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Sec_Tick,
  input  logic        i_Minutes_Inc,
  input  logic        i_Hours_Inc,
  input  logic        i_Mode_Toggle,
  output logic [15:0] o_Time,
  output logic [7:0]  o_Seconds,
  output logic        o_PM,
  output logic        o_Mode_24H,
  output logic        o_Midnight
);

  localparam logic [3:0] c_S_ONES = 4'(START_SECONDS % 10);
  localparam logic [2:0] c_S_TENS = 3'(START_SECONDS / 10);
  localparam logic [3:0] c_M_ONES = 4'(START_MINUTES % 10);
  localparam logic [2:0] c_M_TENS = 3'(START_MINUTES / 10);
  localparam logic [4:0] c_H_BIN  = 5'(START_HOURS);
  localparam logic       c_MODE   = (RESET_24H != 0);

  logic [3:0] r_s_ones;
  logic [2:0] r_s_tens;
  logic [3:0] r_m_ones;
  logic [2:0] r_m_tens;
  logic [4:0] r_h_bin;
  logic       r_mode;
  logic       r_midnight;

  // Convert a 0..23 binary hour into two BCD digits.
  function automatic logic [7:0] f_hour_bcd(input logic [4:0] v);
    if (v >= 5'd20)      f_hour_bcd = {4'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) f_hour_bcd = {4'd1, 4'(v - 5'd10)};
    else                 f_hour_bcd = {4'd0, v[3:0]};
  endfunction

  // Next-value and carry terms. The ">=" compares keep any out-of-range code
  // from ever propagating: it wraps to zero on the next step.
  logic       w_s_ones_wrap, w_sec_carry;
  logic [3:0] w_s_ones_nx;
  logic [2:0] w_s_tens_nx;
  logic       w_m_ones_wrap, w_min_carry;
  logic [3:0] w_m_ones_nx;
  logic [2:0] w_m_tens_nx;
  logic [4:0] w_h_nx;
  logic       w_set, w_min_step, w_hr_step, w_midnight_nx;

  assign w_s_ones_wrap = (r_s_ones >= 4'd9);
  assign w_s_ones_nx   = w_s_ones_wrap ? 4'd0 : r_s_ones + 4'd1;
  assign w_s_tens_nx   = !w_s_ones_wrap     ? r_s_tens :
                         (r_s_tens >= 3'd5) ? 3'd0 : r_s_tens + 3'd1;
  assign w_sec_carry   = w_s_ones_wrap && (r_s_tens >= 3'd5);

  assign w_m_ones_wrap = (r_m_ones >= 4'd9);
  assign w_m_ones_nx   = w_m_ones_wrap ? 4'd0 : r_m_ones + 4'd1;
  assign w_m_tens_nx   = !w_m_ones_wrap     ? r_m_tens :
                         (r_m_tens >= 3'd5) ? 3'd0 : r_m_tens + 3'd1;
  assign w_min_carry   = w_m_ones_wrap && (r_m_tens >= 3'd5);

  assign w_h_nx        = (r_h_bin >= 5'd23) ? 5'd0 : r_h_bin + 5'd1;

  // A manual set pulse owns the minute/hour fields for that cycle: the tick's
  // seconds carry is dropped so a set is never lost or doubled.
  assign w_set         = i_Minutes_Inc | i_Hours_Inc;
  assign w_min_step    = w_set ? i_Minutes_Inc : (i_Sec_Tick & w_sec_carry);
  assign w_hr_step     = w_set ? i_Hours_Inc
                               : (i_Sec_Tick & w_sec_carry & w_min_carry);
  assign w_midnight_nx = !w_set && i_Sec_Tick && w_sec_carry && w_min_carry
                         && (r_h_bin >= 5'd23);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_s_ones   <= c_S_ONES;
      r_s_tens   <= c_S_TENS;
      r_m_ones   <= c_M_ONES;
      r_m_tens   <= c_M_TENS;
      r_h_bin    <= c_H_BIN;
      r_mode     <= c_MODE;
      r_midnight <= 1'b0;
    end else begin
      r_midnight <= w_midnight_nx;
      if (i_Mode_Toggle) begin
        r_mode <= ~r_mode;
      end
      if (i_Sec_Tick) begin
        r_s_ones <= w_s_ones_nx;
        r_s_tens <= w_s_tens_nx;
      end
      if (w_min_step) begin
        r_m_ones <= w_m_ones_nx;
        r_m_tens <= w_m_tens_nx;
      end
      if (w_hr_step) begin
        r_h_bin <= w_h_nx;
      end
    end
  end

  // Display mapping
  logic [4:0] w_h_mod;
  logic [4:0] w_h12;
  logic [4:0] w_h_disp;

  assign w_h_mod  = (r_h_bin >= 5'd12) ? r_h_bin - 5'd12 : r_h_bin;
  assign w_h12    = (w_h_mod == 5'd0) ? 5'd12 : w_h_mod;
  assign w_h_disp = r_mode ? r_h_bin : w_h12;

  assign o_Time     = {f_hour_bcd(w_h_disp), 1'b0, r_m_tens, r_m_ones};
  assign o_Seconds  = {1'b0, r_s_tens, r_s_ones};
  assign o_PM       = !r_mode && (r_h_bin >= 5'd12);
  assign o_Mode_24H = r_mode;
  assign o_Midnight = r_midnight;

endmodule
`default_nettype wire
